fetch_unit: RTL

Instruction-fetch stage plus IF/ID pipeline register for the 16-bit core. It consumes the current PC and PC+2 from the PC updater and fetches from instruction memory over a request/response handshake with variable latency. It presents one instruction at a time to decode, and drives the PC updater's hold input so the PC advances only when a fetched instruction is accepted. It also squashes wrong-path fetches on a flush and stops fetching after a HLT opcode.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/ifid_reg.sv | 42 ++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage of the 16-bit core.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_e;

   localparam logic [3:0]  OP_HLT    = 4'hF;
   localparam logic [15:0] INSTR_NOP = 16'h0000;

   function automatic logic is_hlt(input logic [15:0] instr);
      return instr[15:12] == OP_HLT;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load, hold under decode stall, bubble otherwise, flush clears valid.
module ifid_reg
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic        i_stall,
   input  logic [15:0] i_instr,
   input  logic [15:0] i_pc_plus2,
   output logic        o_valid,
   output logic [15:0] o_instr,
   output logic [15:0] o_pc_plus2
);

   logic        r_valid;
   logic [15:0] r_instr;
   logic [15:0] r_pc_plus2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_instr    <= INSTR_NOP;
         r_pc_plus2 <= 16'h0000;
      end else begin
         // Flush has the last word on valid; data is simply left stale.
         if (i_flush)       r_valid <= 1'b0;
         else if (i_load)   r_valid <= 1'b1;
         else if (!i_stall) r_valid <= 1'b0;
         if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus2 <= i_pc_plus2;
         end
      end
   end

   assign o_valid    = r_valid;
   assign o_instr    = r_instr;
   assign o_pc_plus2 = r_pc_plus2;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch FSM with wrong-path squash, one-entry skid buffer and HLT stop.
// imem handshake: a request transfers when imem_req && imem_ready; exactly one imem_rvalid follows, never in the accept cycle.
module fetch_unit
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [15:0]  pc,
   input  logic [15:0]  pc_plus2,
   input  logic         flush,
   input  logic         id_stall,
   output logic         imem_req,
   output logic [15:0]  imem_addr,
   input  logic         imem_ready,
   input  logic         imem_rvalid,
   input  logic [15:0]  imem_rdata,
   output logic         pc_hold,
   output logic         ifid_valid,
   output logic [15:0]  ifid_instr,
   output logic [15:0]  ifid_pc_plus2,
   output logic         halted,
   output fetch_state_e dbg_state
);

   fetch_state_e r_state;
   logic [15:0]  r_pend_pc2;
   logic         r_squash;
   logic [15:0]  r_skid_instr;
   logic         r_halted;

   fetch_state_e w_next;
   logic         w_req;
   logic         w_accept;
   logic         w_commit;
   logic [15:0]  w_commit_instr;
   logic         w_skid_load;
   logic         w_squash_set;
   logic         w_ifid_free;
   logic         w_ifid_valid;

   assign w_ifid_free = !w_ifid_valid || !id_stall;

   always_comb begin
      w_next         = r_state;
      w_req          = 1'b0;
      w_accept       = 1'b0;
      w_commit       = 1'b0;
      w_commit_instr = r_skid_instr;
      w_skid_load    = 1'b0;
      w_squash_set   = 1'b0;
      unique case (r_state)
         ST_REQ: begin
            // A redirect in this cycle means pc is stale, so no request goes out.
            w_req = !flush;
            if (!flush && imem_ready) begin
               w_accept = 1'b1;
               w_next   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_squash_set = flush;
            if (imem_rvalid) begin
               if (r_squash || flush) begin
                  w_next = ST_REQ;
               end else if (w_ifid_free) begin
                  w_commit       = 1'b1;
                  w_commit_instr = imem_rdata;
                  w_next         = is_hlt(imem_rdata) ? ST_HALT : ST_REQ;
               end else begin
                  w_skid_load = 1'b1;
                  w_next      = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (flush) begin
               w_next = ST_REQ;
            end else if (!id_stall) begin
               w_commit = 1'b1;
               w_next   = is_hlt(r_skid_instr) ? ST_HALT : ST_REQ;
            end
         end
         ST_HALT: begin
            if (flush) w_next = ST_REQ;
         end
         default: w_next = ST_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_REQ;
         r_pend_pc2   <= 16'h0000;
         r_squash     <= 1'b0;
         r_skid_instr <= INSTR_NOP;
         r_halted     <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_halted <= (w_next == ST_HALT);
         if (w_accept) begin
            r_pend_pc2 <= pc_plus2;
            r_squash   <= 1'b0;
         end else if (w_squash_set) begin
            r_squash <= 1'b1;
         end
         if (w_skid_load) r_skid_instr <= imem_rdata;
      end
   end

   ifid_reg u_ifid (
      .clk        (clk),
      .rst_n      (rst),
      .i_load     (w_commit),
      .i_flush    (flush),
      .i_stall    (id_stall),
      .i_instr    (w_commit_instr),
      .i_pc_plus2 (r_pend_pc2),
      .o_valid    (w_ifid_valid),
      .o_instr    (ifid_instr),
      .o_pc_plus2 (ifid_pc_plus2)
   );

   // PC moves only on a commit into IF/ID or on a redirect.
   assign pc_hold    = !(w_commit || flush);
   assign imem_req   = w_req;
   assign imem_addr  = pc;
   assign ifid_valid = w_ifid_valid;
   assign halted     = r_halted;
   assign dbg_state  = r_state;

endmodule
